ahb_lite_master: RTL and testbench
==================================

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have ports: HCLK in 1, bus clock; all logic rising-edge.
REQ-002 SHALL have HRESETn in 1, reset, asynchronous and active-low.
REQ-003 SHALL have AHB inputs: HRDATA in 32, read data; HREADY in 1, transfer done; HRESP in 1, 1=ERROR.
REQ-004 SHALL have application inputs: data_in in 32, write data; addr in 32, address; opcode in 4, [3]=burst and [2:0]=function; enable in 1, request valid; new_trans in 1, start new transfer; busy in 1, insert BUSY in burst.
REQ-005 SHALL have AHB outputs: HADDR out 32; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HTRANS out 2; HMASTLOCK out 1; HWDATA out 32.
REQ-006 SHALL have application outputs: data_out out 32, read data; data_valid out 1, data_out updated; error out 1, error response; WAIT out 1, slave stall.

Function
REQ-007 SHALL decode opcode[2:0]: 0 load byte, 1 load halfword, 2 load word, 3 UART_TX, 4 store byte, 5 store halfword, 6 store word, 7 UART_RX.
REQ-008 SHALL drive HWRITE=opcode[2] and HSIZE=000/001/010 for opcode[1:0]=0/1/2; opcode[1:0]=3 (UART_TX/UART_RX) SHALL use HSIZE=010.
REQ-009 SHALL drive HBURST=001 (INCR) when opcode[3]=1, else 000 (SINGLE); HPROT=4'b0011 constant; HMASTLOCK=0 constant.
REQ-010 SHALL advance the pipeline on a rising edge only when HREADY=1; while HREADY=0, all address-phase outputs and HWDATA SHALL hold.
REQ-011 On advance, SHALL register addr/opcode into HADDR/HWRITE/HSIZE/HBURST and set HTRANS: enable&new_trans -> NONSEQ (10).
REQ-012 enable&!new_trans&opcode[3] while a burst is open -> SEQ (11), or BUSY (01) if busy=1.
REQ-013 All other cases -> IDLE (00).
REQ-014 During BUSY, HADDR SHALL hold the pending beat address; no data phase SHALL follow BUSY or IDLE.
REQ-015 The burst SHALL close when an advance issues IDLE or NONSEQ.
REQ-016 SHALL track a data phase for every NONSEQ/SEQ accepted; data phase = cycle after the address phase.
REQ-017 Write data phase: HWDATA SHALL be data_in registered on the advance that ends the address phase (data_in presented one cycle after addr).
REQ-018 Read data phase: when HREADY=1 and HRESP=0, data_out SHALL register HRDATA and data_valid SHALL pulse 1 for one cycle; data_out SHALL hold otherwise.
REQ-019 WAIT SHALL be combinational = (data phase active & HREADY=0).
REQ-020 Error: HRESP=1 with HREADY=0 (first error cycle) SHALL set HTRANS to IDLE for the pending transfer; error SHALL be 1 for both error cycles and clear after HRESP returns to 0.
REQ-021 Reads completed with HRESP=1 SHALL NOT update data_out nor assert data_valid.

Reset
REQ-022 HRESETn=0 SHALL asynchronously force: HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HTRANS=IDLE, HWDATA=0, data_out=0, data_valid=0, error=0, WAIT=0, burst-open and data-phase flags cleared.
REQ-023 Reset mid-transfer SHALL abandon the transfer; no data_valid SHALL follow release.
REQ-024 First NONSEQ after release SHALL require enable&new_trans sampled on a rising edge with HRESETn=1.

Configuration
REQ-025 Macro AHB_MASTER_ERR_CANCEL_EN defined: first error cycle cancels the queued transfer (REQ-020).
REQ-026 Macro not defined: queued transfer SHALL proceed unchanged after an error; error output still SHALL assert.

Verification
REQ-027 Reset: HRESETn=0 one cycle -> data_out=0, data_valid=0, WAIT=0, HTRANS=00.
REQ-028 Single write: opcode=6, addr=1, new_trans=1, then data_in=AABBCCDD, HREADY=1 -> HADDR=1, HTRANS=10, HWRITE=1, HSIZE=010, next cycle HWDATA=AABBCCDD.
REQ-029 Single read with wait: opcode=2, addr=1; HREADY=0 one data cycle then HRDATA=AABBCCDD, HREADY=1 -> WAIT=1 one cycle, then data_out=AABBCCDD, data_valid pulse.
REQ-030 Back-to-back writes addr=1 then 2 -> HTRANS 10,10; HWDATA AABBCCDD then ABCDEF00 pipelined one cycle behind HADDR.
REQ-031 Burst: opcode=8+5 addr=1 new_trans=1, then opcode=8+6 addr=2, busy=1 one cycle, addr=3 -> HTRANS 10,11,01,11 then 00; HBURST=001.
REQ-032 Error: HREADY=0/HRESP=1 then HREADY=1/HRESP=1 -> error=1 two cycles, HTRANS=00 in first error cycle (macro defined).

Source files
------------

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master
// Description : AHB-Lite bus master. It turns application requests
//               (addr/opcode/enable/new_trans/busy) into pipelined AHB
//               address and data phases. It supports INCR bursts with BUSY
//               insertion, read-data capture and error reporting.
// Config      : AHB_MASTER_ERR_CANCEL_EN - when defined, the first cycle of
//               an ERROR response cancels the transfer queued in the address
//               phase (HTRANS is forced to IDLE).
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  // AHB slave response
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  // application request
  input  logic [31:0] data_in,
  input  logic [31:0] addr,
  input  logic [3:0]  opcode,
  input  logic        enable,
  input  logic        new_trans,
  input  logic        busy,
  // AHB master outputs
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  // application response
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        error,
  output logic        WAIT
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] C_BURST_SINGLE = 3'b000;
  localparam logic [2:0] C_BURST_INCR   = 3'b001;
  localparam logic [3:0] C_HPROT        = 4'b0011;

  // Address-phase registers
  htrans_e     htrans_q,     htrans_d;
  logic [31:0] haddr_q,      haddr_d;
  logic        hwrite_q,     hwrite_d;
  logic [2:0]  hsize_q,      hsize_d;
  logic [2:0]  hburst_q,     hburst_d;
  logic        burst_open_q, burst_open_d;

  // Data-phase registers
  logic        dphase_q,     dphase_d;
  logic        dphase_wr_q,  dphase_wr_d;
  logic [31:0] hwdata_q,     hwdata_d;
  logic [31:0] data_out_q,   data_out_d;
  logic        data_valid_q, data_valid_d;

  // Address phase currently on the bus carries a real transfer
  logic        addr_accept;
  // First ERROR cycle: cancel the queued transfer (only when enabled)
  logic        err_cancel;

  assign addr_accept = (htrans_q == TR_NONSEQ) || (htrans_q == TR_SEQ);

`ifdef AHB_MASTER_ERR_CANCEL_EN
  assign err_cancel = dphase_q & HRESP & ~HREADY;
`else
  assign err_cancel = 1'b0;
`endif

  // Transfer size from function code; UART codes use a word access
  function automatic logic [2:0] size_of(input logic [1:0] func);
    case (func)
      2'd0:    size_of = 3'b000;
      2'd1:    size_of = 3'b001;
      default: size_of = 3'b010;
    endcase
  endfunction

  // Next-state: pipeline advance on HREADY, error cancel while stalled
  always_comb begin
    htrans_d     = htrans_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    hburst_d     = hburst_q;
    burst_open_d = burst_open_q;
    dphase_d     = dphase_q;
    dphase_wr_d  = dphase_wr_q;
    hwdata_d     = hwdata_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    if (HREADY) begin
      // Current address phase moves into the data phase
      dphase_d    = addr_accept;
      dphase_wr_d = hwrite_q;
      // Write data arrives one cycle after its address
      if (addr_accept && hwrite_q) begin
        hwdata_d = data_in;
      end

      // New address phase; during BUSY addr carries the pending beat
      haddr_d  = addr;
      hwrite_d = opcode[2];
      hsize_d  = size_of(opcode[1:0]);
      hburst_d = opcode[3] ? C_BURST_INCR : C_BURST_SINGLE;

      if (enable && new_trans) begin
        htrans_d     = TR_NONSEQ;
        burst_open_d = opcode[3];
      end else if (enable && opcode[3] && burst_open_q) begin
        htrans_d     = busy ? TR_BUSY : TR_SEQ;
        burst_open_d = 1'b1;
      end else begin
        htrans_d     = TR_IDLE;
        burst_open_d = 1'b0;
      end

      // Read completes only on an OKAY response
      if (dphase_q && !dphase_wr_q && !HRESP) begin
        data_out_d   = HRDATA;
        data_valid_d = 1'b1;
      end
    end else if (err_cancel) begin
      // Drop the queued transfer so no data phase follows the error
      htrans_d     = TR_IDLE;
      burst_open_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      htrans_q     <= TR_IDLE;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= 3'b000;
      hburst_q     <= C_BURST_SINGLE;
      burst_open_q <= 1'b0;
      dphase_q     <= 1'b0;
      dphase_wr_q  <= 1'b0;
      hwdata_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      htrans_q     <= htrans_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      hburst_q     <= hburst_d;
      burst_open_q <= burst_open_d;
      dphase_q     <= dphase_d;
      dphase_wr_q  <= dphase_wr_d;
      hwdata_q     <= hwdata_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign HADDR      = haddr_q;
  assign HWRITE     = hwrite_q;
  assign HSIZE      = hsize_q;
  assign HBURST     = hburst_q;
  assign HPROT      = C_HPROT;
  assign HMASTLOCK  = 1'b0;
  // Cancel takes effect already in the first error cycle
  assign HTRANS     = err_cancel ? TR_IDLE : htrans_q;
  assign HWDATA     = hwdata_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  // Error spans both response cycles and drops once HRESP returns low
  assign error      = dphase_q & HRESP;
  assign WAIT       = dphase_q & ~HREADY;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_master
// Description : Directed self-checking bench for ahb_lite_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] data_in;
  logic [31:0] addr;
  logic [3:0]  opcode;
  logic        enable;
  logic        new_trans;
  logic        busy;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] data_out;
  logic        data_valid;
  logic        error;
  logic        WAIT;

  int errors = 0;
  int checks = 0;

  ahb_lite_master dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .data_in   (data_in),
    .addr      (addr),
    .opcode    (opcode),
    .enable    (enable),
    .new_trans (new_trans),
    .busy      (busy),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .data_out  (data_out),
    .data_valid(data_valid),
    .error     (error),
    .WAIT      (WAIT)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    data_in = '0; addr = '0; opcode = '0; enable = 1'b0; new_trans = 1'b0; busy = 1'b0;

    // Reset state
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_HTRANS",     HTRANS,     32'h0);
    check("rst_data_out",   data_out,   32'h0);
    check("rst_data_valid", data_valid, 32'h0);
    check("rst_WAIT",       WAIT,       32'h0);
    check("rst_HADDR",      HADDR,      32'h0);
    check("rst_HWDATA",     HWDATA,     32'h0);
    check("rst_error",      error,      32'h0);
    HRESETn = 1'b1;
    cyc();
    check("idle_after_rst", HTRANS, 32'h0);

    // Single word write
    enable = 1; new_trans = 1; opcode = 4'd6; addr = 32'h1;
    cyc();
    check("wr_HADDR",     HADDR,     32'h1);
    check("wr_HTRANS",    HTRANS,    32'h2);
    check("wr_HWRITE",    HWRITE,    32'h1);
    check("wr_HSIZE",     HSIZE,     32'h2);
    check("wr_HBURST",    HBURST,    32'h0);
    check("wr_HPROT",     HPROT,     32'h3);
    check("wr_HMASTLOCK", HMASTLOCK, 32'h0);
    enable = 0; new_trans = 0; data_in = 32'hAABBCCDD;
    cyc();
    check("wr_HWDATA",     HWDATA, 32'hAABBCCDD);
    check("wr_idle_after", HTRANS, 32'h0);
    check("wr_no_wait",    WAIT,   32'h0);
    cyc();

    // Single read with one wait state
    enable = 1; new_trans = 1; opcode = 4'd2; addr = 32'h1;
    cyc();
    check("rd_HTRANS", HTRANS, 32'h2);
    check("rd_HWRITE", HWRITE, 32'h0);
    check("rd_HSIZE",  HSIZE,  32'h2);
    enable = 0; new_trans = 0;
    cyc();
    HREADY = 0;
    enable = 1; new_trans = 1; addr = 32'h9;
    #1;
    check("rd_WAIT_hi", WAIT, 32'h1);
    cyc();
    check("rd_stall_HADDR",  HADDR,      32'h1);
    check("rd_stall_HTRANS", HTRANS,     32'h0);
    check("rd_stall_valid",  data_valid, 32'h0);
    enable = 0; new_trans = 0;
    HREADY = 1; HRDATA = 32'hAABBCCDD;
    #1;
    check("rd_WAIT_lo", WAIT, 32'h0);
    cyc();
    check("rd_data_out",   data_out,   32'hAABBCCDD);
    check("rd_data_valid", data_valid, 32'h1);
    HRDATA = 32'h0;
    cyc();
    check("rd_valid_pulse", data_valid, 32'h0);
    check("rd_data_hold",   data_out,   32'hAABBCCDD);

    // Back-to-back writes
    enable = 1; new_trans = 1; opcode = 4'd6; addr = 32'h1;
    cyc();
    check("b2b_HTRANS0", HTRANS, 32'h2);
    check("b2b_HADDR0",  HADDR,  32'h1);
    addr = 32'h2; data_in = 32'hAABBCCDD;
    cyc();
    check("b2b_HTRANS1", HTRANS, 32'h2);
    check("b2b_HADDR1",  HADDR,  32'h2);
    check("b2b_HWDATA0", HWDATA, 32'hAABBCCDD);
    enable = 0; new_trans = 0; data_in = 32'hABCDEF00;
    cyc();
    check("b2b_idle",    HTRANS, 32'h0);
    check("b2b_HWDATA1", HWDATA, 32'hABCDEF00);
    cyc();

    // INCR burst with one BUSY cycle
    enable = 1; new_trans = 1; opcode = 4'd13; addr = 32'h1;
    cyc();
    check("bst_HTRANS0", HTRANS, 32'h2);
    check("bst_HBURST",  HBURST, 32'h1);
    check("bst_HSIZE0",  HSIZE,  32'h1);
    check("bst_HWRITE",  HWRITE, 32'h1);
    new_trans = 0; opcode = 4'd14; addr = 32'h2; data_in = 32'h11111111;
    cyc();
    check("bst_HTRANS1", HTRANS, 32'h3);
    check("bst_HADDR1",  HADDR,  32'h2);
    check("bst_HSIZE1",  HSIZE,  32'h2);
    check("bst_HWDATA0", HWDATA, 32'h11111111);
    busy = 1; addr = 32'h3; data_in = 32'h22222222;
    cyc();
    check("bst_HTRANS_busy", HTRANS, 32'h1);
    check("bst_HADDR_busy",  HADDR,  32'h3);
    check("bst_HWDATA1",     HWDATA, 32'h22222222);
    busy = 0; data_in = 32'h33333333;
    cyc();
    check("bst_HTRANS3",      HTRANS, 32'h3);
    check("bst_HADDR3",       HADDR,  32'h3);
    check("bst_no_busy_data", HWDATA, 32'h22222222);
    enable = 0; data_in = 32'h44444444;
    cyc();
    check("bst_end_idle", HTRANS, 32'h0);
    check("bst_HWDATA2",  HWDATA, 32'h44444444);
    enable = 1;
    cyc();
    check("bst_closed", HTRANS, 32'h0);
    enable = 0;
    cyc();

    // Two-cycle ERROR response on a read, with a read queued behind it
    enable = 1; new_trans = 1; opcode = 4'd2; addr = 32'h5;
    cyc();
    check("err_HTRANS0", HTRANS, 32'h2);
    addr = 32'h6;
    cyc();
    check("err_HADDR1", HADDR, 32'h6);
    enable = 0; new_trans = 0;
    HREADY = 0; HRESP = 1;
    #1;
    check("err_cyc1_error", error, 32'h1);
`ifdef AHB_MASTER_ERR_CANCEL_EN
    check("err_cyc1_HTRANS", HTRANS, 32'h0);
`else
    check("err_cyc1_HTRANS", HTRANS, 32'h2);
`endif
    cyc();
    HREADY = 1; HRDATA = 32'hDEADBEEF;
    #1;
    check("err_cyc2_error", error, 32'h1);
    cyc();
    check("err_no_valid",    data_valid, 32'h0);
    check("err_data_hold",   data_out,   32'hAABBCCDD);
    check("err_HTRANS_idle", HTRANS,     32'h0);
    HRESP = 0;
    #1;
    check("err_cleared", error, 32'h0);
    cyc();
`ifdef AHB_MASTER_ERR_CANCEL_EN
    check("err_queued_valid", data_valid, 32'h0);
    check("err_queued_data",  data_out,   32'hAABBCCDD);
`else
    check("err_queued_valid", data_valid, 32'h1);
    check("err_queued_data",  data_out,   32'hDEADBEEF);
`endif
    HRDATA = 32'h0;
    cyc();

    // Reset in the middle of a read data phase
    enable = 1; new_trans = 1; opcode = 4'd3; addr = 32'h40;
    cyc();
    check("uart_HWRITE", HWRITE, 32'h0);
    check("uart_HSIZE",  HSIZE,  32'h2);
    enable = 0; new_trans = 0;
    cyc();
    HREADY = 0;
    #1;
    check("mid_WAIT", WAIT, 32'h1);
    #2;
    HRESETn = 0;
    #1;
    check("async_HTRANS",   HTRANS,   32'h0);
    check("async_HADDR",    HADDR,    32'h0);
    check("async_WAIT",     WAIT,     32'h0);
    check("async_data_out", data_out, 32'h0);
    cyc();
    HRESETn = 1; HREADY = 1; HRDATA = 32'h12345678;
    enable = 1; new_trans = 1; opcode = 4'd0; addr = 32'h80;
    cyc();
    check("post_rst_valid",  data_valid, 32'h0);
    check("post_rst_HTRANS", HTRANS,     32'h2);
    check("post_rst_HSIZE",  HSIZE,      32'h0);
    check("post_rst_data",   data_out,   32'h0);
    enable = 0; new_trans = 0;
    cyc();
    check("post_rst_idle", HTRANS, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
